// File: rtl/csa_seq_adder_pkg.sv
// Shared definitions for the sequential carry-select adder: slice width,
// controller state encoding and index-width helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package csa_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice-index register width. It is never narrower than one bit, so a
  // single-slice build still has a legal index register.
  function automatic int idx_width(input int nslice);
    if (nslice <= 1) return 1;
    return $clog2(nslice);
  endfunction

endpackage

// File: rtl/csa_seq_adder_add_slice4.sv
// 4-bit carry-select adder slice: both carry-in outcomes are precomputed and ci selects one.
// Latency: combinational. Backpressure: none.
// Ports: x, y = nibble operands; ci = carry in; sum = nibble sum; cout = carry out.
module add_slice4
  import csa_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] r0;
  logic [SLICE_W:0] r1;

  assign r0 = {1'b0, x} + {1'b0, y};
  assign r1 = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, 1'b1};

  assign sum  = ci ? r1[SLICE_W-1:0] : r0[SLICE_W-1:0];
  assign cout = ci ? r1[SLICE_W]     : r0[SLICE_W];

endmodule

// File: rtl/csa_seq_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-select slice for WIDTH/4 cycles.
// Latency: out_valid rises NSLICE edges after the accept edge. Issue interval is at least NSLICE+2.
// Backpressure: in_ready is high only in IDLE. The result is held in DONE until out_ready.
// Ports: clk, rst_n (async, active low); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with s, co; busy is high in RUN or DONE.
// Optional: defining CSA_SEQ_ADDER_SUB_EN adds op_sub, which selects a - b (co=1 means no borrow).
module csa_seq_adder
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4 and at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CSA_SEQ_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              co_q, co_d;

  logic [SLICE_W-1:0] nib_a;
  logic [SLICE_W-1:0] nib_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  // Operand nibble for the slice currently being processed
  assign nib_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign nib_b = b_q[idx_q*SLICE_W +: SLICE_W];

  add_slice4 u_slice (
    .x    (nib_a),
    .y    (nib_b),
    .ci   (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          idx_d   = '0;
          state_d = RUN;
`ifdef CSA_SEQ_ADDER_SUB_EN
          // Subtraction is a + ~b + 1. The forced carry replaces cin.
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
        end
      end
      RUN: begin
        // Only the current nibble of s changes. Nibbles not yet processed keep the previous result.
        s_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          co_d    = sl_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Self-checking bench for csa_seq_adder with a WIDTH=16 instance and a WIDTH=4 instance.
// Latency: n/a. Backpressure: out_ready is held low in DONE to check that the result stays stable.
// Ports: none. Subtract vectors are included when CSA_SEQ_ADDER_SUB_EN is defined.
module tb_csa_seq_adder;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  a, b, s;
  logic          cin, co, op_sub;

  logic          in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]    a4, b4, s4;
  logic          cin4, co4, op_sub4;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];  // {co, s} of each accepted operation, in order

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] es;
    logic         eco;
    string        nm;
  } vec_t;

  vec_t vecs[$];

  csa_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CSA_SEQ_ADDER_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .busy      (busy)
  );

  csa_seq_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef CSA_SEQ_ADDER_SUB_EN
    .op_sub    (op_sub4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .s         (s4),
    .co        (co4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // One full transaction. The expected result is pushed on the accept edge and popped at handoff.
  // hold = number of DONE cycles with out_ready low. When poke is set, a competing
  // in_valid is presented during those cycles and must be ignored.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                        input logic vsub, input logic [W-1:0] es, input logic eco,
                        input int hold, input bit poke, input string nm);
    int n;
    logic [W:0] e;
    @(negedge clk);
    a = va; b = vb; cin = vcin; op_sub = vsub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    exp_q.push_back({eco, es});
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({nm, "_busy"}, busy, 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    chk({nm, "_latency"}, n, NS);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        a = 16'h0001; b = 16'h0001; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      end
      chk({nm, "_hold_s"},     s,         es);
      chk({nm, "_hold_co"},    co,        eco);
      chk({nm, "_hold_rdy"},   in_ready,  0);
      chk({nm, "_hold_valid"}, out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({nm, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, "_s"},  s,  e[W-1:0]);
      chk({nm, "_co"}, co, e[W]);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_post_valid"}, out_valid, 0);
    chk({nm, "_post_rdy"},   in_ready,  1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; op_sub4 = 1'b0;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "add_1234_4321"});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple_ffff_1"});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "cin_ffff_0"});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "zero"});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "msb_carry"});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, "abcd_1111_c1"});
`ifdef CSA_SEQ_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, "sub_5_7"});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, "sub_7_5"});
`endif

    // Reset state
    #12;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_s",         s,         0);
    chk("rst_co",        co,        0);
    chk("rst4_in_ready", in_ready4, 1);
    chk("rst4_s",        s4,        0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
             vecs[i].es, vecs[i].eco, i % 3, 1'b0, vecs[i].nm);
    end

    // Backpressure: the result must stay stable, and a competing request is ignored.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 6, 1'b1, "bp_hold");
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0, 1'b0, "bp_next");

    // Reset asserted during the second RUN cycle
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_s",     s,         0);
    chk("mid_rst_co",    co,        0);
    chk("mid_rst_rdy",   in_ready,  1);
    chk("mid_rst_busy",  busy,      0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1, 1'b0, "post_rst");

    // WIDTH=4 instance: RUN lasts one cycle
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; in_valid4 = 1'b1;
    chk("w4_in_ready", in_ready4, 1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    chk("w4_busy",        busy4,      1);
    chk("w4_early_valid", out_valid4, 0);
    @(posedge clk);
    #1;
    chk("w4_valid", out_valid4, 1);
    chk("w4_s",     s4,         4'h2);
    chk("w4_co",    co4,        1);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    chk("w4_post_valid", out_valid4, 0);
    chk("w4_post_rdy",   in_ready4,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
